// File: rtl/fp_mac_pkg.sv
// Shared MAC datapath types, fp32 constants and the round-robin pick helper.
package fp_mac_pkg;

    localparam int unsigned FP_EXP_W = 8;
    localparam int unsigned FP_MAN_W = 23;
    localparam int unsigned FP_W     = 1 + FP_EXP_W + FP_MAN_W;
    localparam int unsigned MAX_REQ  = 32;

    typedef logic [FP_W-1:0] fp32_t;

    localparam fp32_t FP_ONE  = 32'h3F800000;
    localparam fp32_t FP_ZERO = 32'h0;

    // One-hot grant for the first valid lane scanning ptr, ptr+1, ... mod n (n <= MAX_REQ).
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                   input int unsigned ptr,
                                                   input int unsigned n);
        logic [MAX_REQ-1:0] g;
        logic               found;
        int unsigned        idx;
        g     = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < n && !found) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (valid[idx[4:0]]) begin
                    g[idx[4:0]] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/fp_arb_tag_pipe.sv
// Lane-tag delay line matching the shared adder latency; async clear drops in-flight tags.
module fp_arb_tag_pipe #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADD_LATENCY = 2,
    parameter int unsigned TAG_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag
);

    logic             pv [ADD_LATENCY];
    logic [TAG_W-1:0] pt [ADD_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ADD_LATENCY; i++) begin
                pv[i] <= 1'b0;
                pt[i] <= '0;
            end
        end else begin
            pv[0] <= in_valid;
            pt[0] <= in_tag;
            for (int unsigned i = 1; i < ADD_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pt[i] <= pt[i-1];
            end
        end
    end

    assign out_valid = pv[ADD_LATENCY-1];
    assign out_tag   = pt[ADD_LATENCY-1];

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one fp32 adder among NUM_REQ lanes, results routed back by tag.
// Optional per-lane grant counters enabled by `FP_ARB_STATS_EN.
module fp_add_arbiter
    import fp_mac_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADD_LATENCY = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*32-1:0]  req_a,
    input  logic [NUM_REQ*32-1:0]  req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [31:0]            add_a,
    output logic [31:0]            add_b,
    input  logic [31:0]            add_result,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_data
`ifdef FP_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0] stat_grants
`endif
);

    localparam int unsigned TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 1 || NUM_REQ > MAX_REQ || ADD_LATENCY < 1 || CNT_W < 1) begin : g_param_check
        $error("fp_add_arbiter: parameter out of range");
    end

    logic [TAG_W-1:0]   ptr, ptr_nxt, lane, pipe_tag;
    logic [MAX_REQ-1:0] valid_ext, grant_full;
    logic               accept, pipe_valid;
    fp32_t              sel_a, sel_b;
    logic [NUM_REQ-1:0] rsp_onehot;

    // Grant is masked during reset so nothing can be accepted while state is being cleared.
    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = req_valid;
        grant_full               = rr_pick(valid_ext, 32'(ptr), NUM_REQ);
        req_ready                = rst_n ? grant_full[NUM_REQ-1:0] : '0;
        accept                   = |req_ready;
        lane                     = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (grant_full[i]) lane = TAG_W'(i);
        end
        sel_a = FP_ZERO;
        sel_b = FP_ZERO;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel_a = req_a[32*i +: 32];
                sel_b = req_b[32*i +: 32];
            end
        end
        ptr_nxt    = (lane == TAG_W'(NUM_REQ - 1)) ? '0 : lane + 1'b1;
        rsp_onehot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pipe_valid && pipe_tag == TAG_W'(i)) rsp_onehot[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            add_a     <= FP_ZERO;
            add_b     <= FP_ZERO;
            rsp_valid <= '0;
            rsp_data  <= FP_ZERO;
        end else begin
            if (accept) begin
                ptr   <= ptr_nxt;
                add_a <= sel_a;
                add_b <= sel_b;
            end
            rsp_valid <= rsp_onehot;
            if (pipe_valid) rsp_data <= add_result;
        end
    end

    fp_arb_tag_pipe #(
        .NUM_REQ     (NUM_REQ),
        .ADD_LATENCY (ADD_LATENCY),
        .TAG_W       (TAG_W)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (accept),
        .in_tag    (lane),
        .out_valid (pipe_valid),
        .out_tag   (pipe_tag)
    );

`ifdef FP_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grants <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && stat_grants[i*CNT_W +: CNT_W] != '1)
                    stat_grants[i*CNT_W +: CNT_W] <= stat_grants[i*CNT_W +: CNT_W] + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed self-checking bench for fp_add_arbiter with a registered fp32 adder model.
module tb_fp_add_arbiter;
    import fp_mac_pkg::*;

    localparam int unsigned NR  = 4;
    localparam int unsigned LAT = 2;
    localparam int unsigned CW  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid;
    logic [NR*32-1:0]  req_a, req_b;
    logic [NR-1:0]     req_ready;
    logic [31:0]       add_a, add_b, add_result;
    logic [NR-1:0]     rsp_valid;
    logic [31:0]       rsp_data;
`ifdef FP_ARB_STATS_EN
    logic [NR*CW-1:0]  stat_grants;
`endif

    int checks = 0;
    int errors = 0;

    fp_add_arbiter #(
        .NUM_REQ     (NR),
        .ADD_LATENCY (LAT),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_result  (add_result),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data)
`ifdef FP_ARB_STATS_EN
        ,
        .stat_grants (stat_grants)
`endif
    );

    always #5 clk = ~clk;

    // fp32 <-> real conversions, exact for the normal/zero values used here.
    function automatic real f2r(input logic [31:0] a);
        logic [10:0] e11;
        if (a[30:0] == 31'd0) return $bitstoreal({a[31], 63'd0});
        e11 = 11'(a[30:23]) + 11'd896;
        return $bitstoreal({a[31], e11, a[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        logic [10:0] e11;
        b = $realtobits(r);
        if (b[62:0] == 63'd0) return {b[63], 31'd0};
        e11 = b[62:52] - 11'd896;
        return {b[63], e11[7:0], b[51:29]};
    endfunction

    function automatic logic [31:0] fpadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    // Adder model: add_a/add_b register plus one result register gives the 2-edge latency.
    always_ff @(posedge clk) add_result <= fpadd(add_a, add_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] exp_d;

    initial begin
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rst_n     = 1'b0;

        // Reset state, with all lanes requesting to confirm the grant is held off.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_add_a", add_a, 32'h0);
        chk("rst_add_b", add_b, 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
`ifdef FP_ARB_STATS_EN
        chk("rst_stats", 32'(stat_grants), 32'h0);
`endif
        req_valid = '0;
        rst_n     = 1'b1;

        // 1: single request on lane 1, 1.0 + 2.0.
        @(negedge clk);
        req_valid       = 4'b0010;
        req_a[63:32]    = FP_ONE;
        req_b[63:32]    = 32'h40000000;
        #1 chk("t1_grant", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("t1_add_a", add_a, FP_ONE);
        chk("t1_add_b", add_b, 32'h40000000);
        chk("t1_no_rsp1", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        #1 chk("t1_no_rsp2", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        #1;
        chk("t1_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("t1_rsp_data", rsp_data, 32'h40400000);
        @(negedge clk);
        #1 chk("t1_rsp_done", 32'(rsp_valid), 32'h0);

        // 2: all lanes valid for 8 cycles; lane i carries A=2^i.
        pulse_reset();
        for (int i = 0; i < 4; i++) req_a[32*i +: 32] = FP_ONE + (32'(i) << 23);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c < 8) begin
                req_valid = '1;
                for (int i = 0; i < 4; i++) req_b[32*i +: 32] = (c < 4) ? FP_ONE : 32'h40000000;
            end else begin
                req_valid = '0;
            end
            #1;
            if (c < 8) chk($sformatf("t2_grant%0d", c), 32'(req_ready), 32'(1 << (c % 4)));
            if (c >= 3 && c < 11) begin
                exp_d = fpadd(FP_ONE + (32'((c - 3) % 4) << 23), (c - 3 < 4) ? FP_ONE : 32'h40000000);
                chk($sformatf("t2_rsp_valid%0d", c - 3), 32'(rsp_valid), 32'(1 << ((c - 3) % 4)));
                chk($sformatf("t2_rsp_data%0d", c - 3), rsp_data, exp_d);
            end
            if (c == 11) chk("t2_rsp_end", 32'(rsp_valid), 32'h0);
        end

        // 3: skip-ahead from ptr=1, then wrap from lane 3 back to lane 0.
        pulse_reset();
        @(negedge clk);
        req_valid = 4'b0001;
        #1 chk("t3_pre", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 4'b0101;
        #1 chk("t3_first_lane2", 32'(req_ready), 32'h4);
        @(negedge clk);
        #1 chk("t3_then_lane0", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 4'b1000;
        #1 chk("t3_wrap_lane3", 32'(req_ready), 32'h8);
        @(negedge clk);
        req_valid = 4'b0001;
        #1 chk("t3_wrap_lane0", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 4'b0011;
        #1 chk("t3_ptr_is_1", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);

        // 4: asynchronous reset mid-flight after two accepts (lanes 2 and 3).
        @(negedge clk);
        req_a[95:64]  = 32'h40800000;
        req_b[95:64]  = FP_ONE;
        req_a[127:96] = 32'h41000000;
        req_b[127:96] = FP_ONE;
        req_valid     = 4'b1100;
        #1 chk("t4_grant_lane2", 32'(req_ready), 32'h4);
        @(negedge clk);
        #1 chk("t4_grant_lane3", 32'(req_ready), 32'h8);
        @(negedge clk);
        #1 chk("t4_pre_add_a", add_a, 32'h41000000);
        #1 rst_n = 1'b0;
        #1;
        chk("t4_rst_ready", 32'(req_ready), 32'h0);
        chk("t4_rst_add_a", add_a, 32'h0);
        chk("t4_rst_add_b", add_b, 32'h0);
        chk("t4_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("t4_rst_rsp_data", rsp_data, 32'h0);
        @(negedge clk);
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1 chk($sformatf("t4_no_rsp%0d", k), 32'(rsp_valid), 32'h0);
        end
        @(negedge clk);
        req_valid = '1;
        #1 chk("t4_first_after_rst", 32'(req_ready), 32'h1);

        // 5: -5.0 + 5.0 on lane 3, then idle with junk on the operand buses.
        @(negedge clk);
        req_valid     = 4'b1000;
        req_a[127:96] = 32'hC0A00000;
        req_b[127:96] = 32'h40A00000;
        #1 chk("t5_grant", 32'(req_ready), 32'h8);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = '0;
                req_a     = {NR{32'hDEADBEEF}};
                req_b     = {NR{32'h12345678}};
            end
            #1;
            chk($sformatf("t5_add_a_hold%0d", k), add_a, 32'hC0A00000);
            chk($sformatf("t5_add_b_hold%0d", k), add_b, 32'h40A00000);
            if (k == 3) begin
                chk("t5_rsp_valid", 32'(rsp_valid), 32'h8);
                chk("t5_rsp_data", rsp_data, 32'h00000000);
            end
            if (k > 3) chk($sformatf("t5_rsp_quiet%0d", k), 32'(rsp_valid), 32'h0);
        end

`ifdef FP_ARB_STATS_EN
        // 6: 2-bit grant counter on lane 0 saturates at 3.
        pulse_reset();
        #1 chk("t6_stats_clear", 32'(stat_grants), 32'h0);
        @(negedge clk);
        req_valid = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            #1 chk($sformatf("t6_stats%0d", k), 32'(stat_grants), (k > 3) ? 32'd3 : 32'(k));
        end
        req_valid = '0;
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
